// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and operand saturation
// for the shared bin2bcd converter arbiter.
package bcd_pkg;

    localparam int DW          = 20;
    localparam int BCD_MAX     = 99999;
    localparam int CONV_PERIOD = 22;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SYNC,
        WAIT,
        DELIVER
    } state_t;

    // Returns {ovf, operand}: operand clamped to the 5-digit range.
    function automatic logic [DW:0] saturate(input logic [DW-1:0] v);
        if (v > DW'(BCD_MAX)) begin
            return {1'b1, DW'(BCD_MAX)};
        end
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester-side bundle: level requests, operands and the
// tagged result returned with the ack pulse.
interface bcd_conv_arbiter_if
    import bcd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 3
);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_bin;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      result_bcd;
    logic [IDW-1:0]     result_id;
    logic               result_valid;
    logic               result_ovf;
    logic               result_err;
    logic               busy;

    modport master (
        output req,
        output req_bin,
        input  ack,
        input  result_bcd,
        input  result_id,
        input  result_valid,
        input  result_ovf,
        input  result_err,
        input  busy
    );

    modport slave (
        input  req,
        input  req_bin,
        output ack,
        output result_bcd,
        output result_id,
        output result_valid,
        output result_ovf,
        output result_err,
        output busy
    );

endinterface

// File: rtl/bcd_conv_arbiter_rr.sv
// Round-robin next-winner search starting just above ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  gnt,
    output logic            any
);

    logic hi;
    logic lo;

    // First pass takes indices above ptr; second pass wraps to the bottom.
    always_comb begin
        gnt = '0;
        hi  = 1'b0;
        lo  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !hi && (IDW'(i) > ptr)) begin
                hi  = 1'b1;
                gnt = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !hi && !lo) begin
                lo  = 1'b1;
                gnt = IDW'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one free-running bin2bcd converter between NREQ requesters,
// returning saturated, requester-tagged 5-digit BCD results.
module bcd_conv_arbiter
    import bcd_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int IDW         = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_conv_arbiter_if.slave   bus,
    output logic [DW-1:0]       conv_bin,
    input  logic [DW-1:0]       conv_bcd,
    input  logic                conv_done
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t         state;
    state_t         nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] gnt;
    logic           any;
    logic           done_d;
    logic           done_rise;
    logic           ovf;
    logic           tmo;
    logic [TW-1:0]  timer;
    logic [DW-1:0]  slice;
    logic [DW-1:0]  res_bcd;
    logic [IDW-1:0] res_id;
    logic           res_ovf;
    logic           res_err;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req  (bus.req),
        .ptr  (ptr),
        .gnt  (gnt),
        .any  (any)
    );

    assign done_rise        = conv_done & ~done_d;
    assign tmo              = (timer == TW'(TIMEOUT_CYC - 1));
    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = (state == DELIVER);
    assign bus.result_bcd   = res_bcd;
    assign bus.result_id    = res_id;
    assign bus.result_ovf   = res_ovf;
    assign bus.result_err   = res_err;

    always_comb begin
        bus.ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.ack[i] = (state == DELIVER) && (sel == IDW'(i));
        end
    end

    always_comb begin
        slice = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) begin
                slice = bus.req_bin[DW*i +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (any) nxt = GRANT;
            GRANT:   nxt = any ? SYNC : IDLE;
            SYNC: begin
                if (done_rise) begin
                    nxt = WAIT;
                end else if (tmo) begin
                    nxt = DELIVER;
                end
            end
            WAIT:    if (done_rise || tmo) nxt = DELIVER;
            DELIVER: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Result fields update only on the way into DELIVER, so they
    // hold their last values in every other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= IDW'(NREQ - 1);
            sel      <= '0;
            ovf      <= 1'b0;
            conv_bin <= '0;
            done_d   <= 1'b0;
            timer    <= '0;
            res_bcd  <= '0;
            res_id   <= '0;
            res_ovf  <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            done_d <= conv_done;
            case (state)
                GRANT: begin
                    if (any) begin
                        sel             <= gnt;
                        ptr             <= gnt;
                        {ovf, conv_bin} <= saturate(slice);
                        timer           <= '0;
                    end
                end
                SYNC: begin
                    if (done_rise) begin
                        timer <= '0;
                    end else if (tmo) begin
                        res_bcd <= '0;
                        res_err <= 1'b1;
                        res_id  <= sel;
                        res_ovf <= ovf;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT: begin
                    if (done_rise) begin
                        res_bcd <= conv_bcd;
                        res_err <= 1'b0;
                        res_id  <= sel;
                        res_ovf <= ovf;
                    end else if (tmo) begin
                        res_bcd <= '0;
                        res_err <= 1'b1;
                        res_id  <= sel;
                        res_ovf <= ovf;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a free-running
// 22-cycle converter model.
module tb_bcd_conv_arbiter;
    import bcd_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 3;
    localparam int TMO  = 64;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [19:0]   conv_bin;
    logic [19:0]   conv_bcd;
    logic          conv_done;

    bcd_conv_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    bcd_conv_arbiter #(
        .NREQ        (NREQ),
        .IDW         (IDW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .conv_bin  (conv_bin),
        .conv_bcd  (conv_bcd),
        .conv_done (conv_done)
    );

    always #5 clk = ~clk;

    logic [4:0]  cnt     = '0;
    logic [19:0] latched = '0;
    logic [19:0] cbcd    = '0;
    logic        done_r  = 1'b0;
    logic        stuck   = 1'b0;

    function automatic logic [19:0] to_bcd(input logic [19:0] b);
        logic [19:0] r;
        int v;
        r = '0;
        v = int'(b);
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Latch at count 0, finish at CONV_PERIOD-1, done high the cycle after.
    always @(posedge clk) begin
        cnt <= (cnt == 5'(CONV_PERIOD - 1)) ? 5'd0 : cnt + 5'd1;
        if (cnt == 5'd0) latched <= conv_bin;
        if (cnt == 5'(CONV_PERIOD - 1)) begin
            cbcd   <= to_bcd(latched);
            done_r <= 1'b1;
        end
        if (cnt == 5'd2) done_r <= 1'b0;
    end

    assign conv_bcd  = cbcd;
    assign conv_done = done_r & ~stuck;

    int n_checks = 0;
    int n_errors = 0;

    logic [19:0]     r_bcd;
    logic [IDW-1:0]  r_id;
    logic            r_ovf;
    logic            r_err;
    logic            r_got;
    logic [NREQ-1:0] r_ack;
    logic            p_valid;
    logic [NREQ-1:0] p_ack;
    logic [19:0]     p_bcd;
    int              lat;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int limit);
        r_got = 1'b0;
        lat   = 0;
        for (int c = 0; c < limit && !r_got; c++) begin
            @(negedge clk);
            if (bus.result_valid) begin
                r_got = 1'b1;
                r_bcd = bus.result_bcd;
                r_id  = bus.result_id;
                r_ovf = bus.result_ovf;
                r_err = bus.result_err;
                r_ack = bus.ack;
            end else if (bus.busy) begin
                lat++;
            end
        end
    endtask

    task automatic do_req(input int i, input logic [19:0] v);
        @(negedge clk);
        bus.req_bin[20*i +: 20] = v;
        bus.req[i] = 1'b1;
        wait_valid(200);
        bus.req[i] = 1'b0;
        @(negedge clk);
        p_valid = bus.result_valid;
        p_ack   = bus.ack;
        p_bcd   = bus.result_bcd;
    endtask

    task automatic expect_txn(input string t, input int id,
                              input logic [19:0] bcd,
                              input logic ovf, input logic err);
        logic [NREQ-1:0] e_ack;
        e_ack = NREQ'(1) << id;
        check({t, "_valid"}, r_got, 1);
        check({t, "_id"}, r_id, id);
        check({t, "_bcd"}, r_bcd, bcd);
        check({t, "_ovf"}, r_ovf, ovf);
        check({t, "_err"}, r_err, err);
        check({t, "_ack"}, r_ack, e_ack);
        check({t, "_valid_after"}, p_valid, 0);
        check({t, "_ack_after"}, p_ack, 0);
        check({t, "_hold"}, p_bcd, bcd);
    endtask

    logic [19:0] f_op  [NREQ];
    logic [19:0] f_exp [NREQ];

    initial begin
        bus.req     = '0;
        bus.req_bin = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", bus.ack, 0);
        check("rst_valid", bus.result_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_bcd", bus.result_bcd, 0);
        check("rst_id", bus.result_id, 0);
        check("rst_ovf", bus.result_ovf, 0);
        check("rst_err", bus.result_err, 0);
        check("rst_conv_bin", conv_bin, 0);
        rst_n = 1'b1;

        do_req(2, 20'd12345);
        expect_txn("single", 2, 20'h12345, 1'b0, 1'b0);
        check("single_lat", (lat >= 24 && lat <= 46), 1);

        do_req(1, 20'hFFFFF);
        expect_txn("sat_fffff", 1, 20'h99999, 1'b1, 1'b0);
        do_req(3, 20'd100000);
        expect_txn("sat_100000", 3, 20'h99999, 1'b1, 1'b0);
        do_req(0, 20'd99999);
        expect_txn("max_99999", 0, 20'h99999, 1'b0, 1'b0);
        do_req(2, 20'd0);
        expect_txn("zero", 2, 20'h00000, 1'b0, 1'b0);

        do_req(1, 20'd11111);
        expect_txn("pre_discard", 1, 20'h11111, 1'b0, 1'b0);
        for (int c = 0; c < 40 && cnt != 5'd18; c++) @(negedge clk);
        check("align_cnt", cnt, 18);
        do_req(1, 20'd54321);
        expect_txn("discard", 1, 20'h54321, 1'b0, 1'b0);

        stuck = 1'b1;
        do_req(3, 20'd777);
        expect_txn("timeout", 3, 20'h00000, 1'b0, 1'b1);
        check("timeout_lat", lat, TMO + 1);
        stuck = 1'b0;
        do_req(0, 20'd4321);
        expect_txn("after_tmo", 0, 20'h04321, 1'b0, 1'b0);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        f_op[0]  = 20'd1000;  f_exp[0] = 20'h01000;
        f_op[1]  = 20'd2001;  f_exp[1] = 20'h02001;
        f_op[2]  = 20'd3002;  f_exp[2] = 20'h03002;
        f_op[3]  = 20'd45678; f_exp[3] = 20'h45678;
        for (int i = 0; i < NREQ; i++) bus.req_bin[20*i +: 20] = f_op[i];
        bus.req = '1;
        for (int k = 0; k < 6; k++) begin
            wait_valid(200);
            check("fair_valid", r_got, 1);
            check("fair_id", r_id, k % NREQ);
            check("fair_bcd", r_bcd, f_exp[k % NREQ]);
        end
        bus.req = '0;

        @(negedge clk);
        bus.req = '1;
        for (int c = 0; c < 100 && dut.state != WAIT; c++) @(negedge clk);
        check("reach_wait", (dut.state == WAIT), 1);
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_rst_ack", bus.ack, 0);
            check("mid_rst_valid", bus.result_valid, 0);
            check("mid_rst_busy", bus.busy, 0);
        end
        rst_n = 1'b1;
        wait_valid(200);
        check("post_rst_valid", r_got, 1);
        check("post_rst_id", r_id, 0);
        check("post_rst_bcd", r_bcd, 20'h01000);
        bus.req = '0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one free-running bin2bcd converter between NREQ requesters, e.g. temperature, humidity, light and motor-position readouts feeding the display path.
- Arbitrates round-robin and saturates the operand to 99999.
- Drives the converter input and waits until a conversion has started after that input was applied.
- Returns the 5-digit BCD result, tagged with the requester index.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 3, width of result_id; must satisfy 2**IDW >= NREQ.
- TIMEOUT_CYC, 64, maximum cycles allowed in a wait state before an error completion.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  active-low reset.
- req  in  NREQ  per-requester level request; held until the matching ack.
- req_bin  in  NREQ*20  flattened operands; slice i is req_bin[20*i+19:20*i].
- ack  out  NREQ  one-cycle pulse to the served requester.
- result_bcd  out  20  five BCD digits, most significant digit at [19:16].
- result_id  out  IDW  index of the served requester.
- result_valid  out  1  one-cycle pulse, coincident with ack.
- result_ovf  out  1  operand was greater than 99999 and was saturated.
- result_err  out  1  converter timeout; result_bcd is 0.
- busy  out  1  high in every state except IDLE.
- conv_bin  out  20  operand to the converter.
- conv_bcd  in  20  converter result.
- conv_done  in  1  converter done level.

Behaviour:
- Reset and clocking:
  - One clock (clk). Reset is asynchronous and active-low (rst_n).
  - Reset values: all outputs 0, FSM in IDLE, round-robin pointer at NREQ-1, done_d = 0, timer = 0.
  - rst_n asserted mid-operation aborts the transaction immediately. No ack is issued for it.
- Done edge: done_rise = conv_done & ~done_d, where done_d is conv_done registered.
- Converter model:
  - The converter free-runs with a 22-cycle period. It latches its operand one cycle before op begins.
  - conv_done rises on the cycle after its finish state.
  - The first done_rise after conv_bin changes may belong to a conversion that latched the old operand, so it is discarded.
- FSM states:
  - IDLE: if any req bit is set, go to GRANT.
  - GRANT:
    - Select the first set req bit searching from ptr+1 upward, wrapping modulo NREQ.
    - Latch the winning index into sel and set ptr = sel.
    - Capture the operand: if req_bin slice > 99999, set op = 99999 and ovf = 1; otherwise op = slice and ovf = 0.
    - Drive conv_bin = op, registered, and hold it until DELIVER.
    - Clear timer. Go to SYNC.
  - SYNC: on done_rise, clear timer and go to WAIT.
  - WAIT: on done_rise, capture conv_bcd into result_bcd and go to DELIVER.
  - Timeout: in SYNC or WAIT, timer increments each cycle. At timer == TIMEOUT_CYC-1 without a done_rise, set result_bcd = 0 and err = 1, then go to DELIVER.
  - DELIVER (one cycle):
    - Pulse ack[sel] and result_valid.
    - Drive result_id = sel, result_ovf = ovf and result_err = err.
    - Go to IDLE. The next grant is therefore at the earliest two cycles later.
- Latency: grant to result_valid is at least 24 and at most 46 cycles with a healthy converter.
- Request rules:
  - req_bin is sampled only in GRANT.
  - Changes to req_bin or req after grant do not affect the transaction.
  - A req dropped mid-transaction still completes, and its ack is emitted.
  - A requester is never granted twice in a row while any other requester has req set.
  - Simultaneous requests are resolved purely by the pointer.
- Outside DELIVER: result_bcd, result_id, result_ovf and result_err hold their last values. ack and result_valid are 0.
- Boundary values:
  - Operand 99999 gives ovf = 0.
  - Operand 100000 gives ovf = 1 and result_bcd = 0x99999.
  - Operand 0 gives result_bcd = 0x00000.
- Width rules:
  - Saturation compares against 20'd99999.
  - timer is wide enough for TIMEOUT_CYC-1.
  - The pointer wraps modulo NREQ, including for non-power-of-2 NREQ.

Decomposition:
- Shared package bcd_pkg holds:
  - the BCD_MAX = 99999 constant;
  - the operand/result width constant, 20;
  - the conversion-period constant, 22;
  - the state encoding IDLE, GRANT, SYNC, WAIT, DELIVER.
- One sub-module, rr_arbiter. Combinational next-winner logic takes req and ptr and returns a grant index plus an any flag.
- The FSM, saturation, timer and edge detect stay in the top module.

Test Plan:
- Single request: req[2] = 1 with operand 12345 -> exactly one ack[2] and result_valid; result_bcd = 0x12345, result_id = 2, ovf = 0, err = 0; grant-to-valid latency between 24 and 46 cycles.
- Saturation: operand 20'hFFFFF (1048575) -> result_bcd = 0x99999 and ovf = 1. Operand 99999 -> ovf = 0. Operand 0 -> 0x00000.
- Fairness: all four req held continuously with distinct operands -> acks in order 0, 1, 2, 3, 0, 1 and every result matches its requester's operand.
- Discard check: change the operand right before a converter done edge -> the result reflects the new operand, never the previous one.
- Timeout: conv_done stuck at 0 -> valid pulse after TIMEOUT_CYC cycles in SYNC, with err = 1 and result_bcd = 0; the next request is served normally.
- Reset mid-WAIT: rst_n low for 3 cycles -> ack and result_valid stay 0, busy = 0, and the first grant after reset goes to requester 0.
